// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and decoded control payload for mem_ctrl_fsm.
package mem_ctrl_pkg;

  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_BEQ   = 1;
  localparam int unsigned OP_SW    = 2;
  localparam int unsigned OP_LW    = 3;
  localparam int unsigned OP_ADDI  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef struct packed {
    logic alusrc;
    logic memtoreg;
    logic regdst;
    logic branch;
  } ctrl_t;

  // Opcodes outside the defined set execute as a NOP
  function automatic logic op_known(input int unsigned op);
    return op <= OP_ADDI;
  endfunction

  // Instruction-class control bits, held from EXEC until the instruction ends
  function automatic ctrl_t decode_ctrl(input int unsigned op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: c.regdst   = 1'b1;
      OP_BEQ:   c.branch   = 1'b1;
      OP_SW:    c.alusrc   = 1'b1;
      OP_LW: begin
        c.alusrc   = 1'b1;
        c.memtoreg = 1'b1;
      end
      OP_ADDI:  c.alusrc   = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_ctrl_fsm_sp_ram_sync.sv
// Single-port RAM: synchronous write, registered read, write-first on collision.
module sp_ram_sync #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  // Read register; holds the last fetched word between reads
  always_ff @(posedge clk) begin
    if (reset)   dout <= '0;
    else if (re) dout <= we ? din : mem[addr];
  end

endmodule

// File: rtl/mem_ctrl_fsm.sv
// Program RAM behind a multi-cycle fetch/decode/exec/mem/wb control FSM.
module mem_ctrl_fsm
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned OPC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              wea,
  output logic [DATA_W-1:0] douta,
  output logic              busy,
  output logic              done,
  output logic              ALUSrc,
  output logic              MemtoReg,
  output logic              RegDst,
  output logic              Branch,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              RegWrite
);

  state_e            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [OPC_W-1:0]  opc_q;
  ctrl_t             ctrl_q;
  logic [OPC_W-1:0]  opc_d;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;

  assign opc_d    = douta[DATA_W-1 -: OPC_W];
  assign ram_we   = wea && (state == S_IDLE) && !reset;
  assign ram_re   = (state == S_FETCH);
  assign ram_addr = (state == S_IDLE) ? addr : addr_q;

  sp_ram_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .din   (din),
    .dout  (douta)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Fetch address and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      opc_q  <= '0;
      ctrl_q <= '0;
    end else begin
      if (state == S_IDLE && start) addr_q <= addr;
      if (state == S_DECODE) begin
        opc_q  <= opc_d;
        ctrl_q <= decode_ctrl(32'(opc_d));
      end
    end
  end

  // Next-state: path through EXEC/MEM/WB selected by opcode
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = op_known(32'(opc_d)) ? S_EXEC : S_IDLE;
      S_EXEC: begin
        if (opc_q == OPC_W'(OP_BEQ))
          next_state = S_IDLE;
        else if (opc_q == OPC_W'(OP_SW) || opc_q == OPC_W'(OP_LW))
          next_state = S_MEM;
        else
          next_state = S_WB;
      end
      S_MEM:    next_state = (opc_q == OPC_W'(OP_LW)) ? S_WB : S_IDLE;
      S_WB:     next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state and instruction register only
  always_comb begin
    busy     = (state != S_IDLE);
    done     = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      ALUSrc   = ctrl_q.alusrc;
      MemtoReg = ctrl_q.memtoreg;
      RegDst   = ctrl_q.regdst;
      Branch   = ctrl_q.branch;
    end
    case (state)
      S_DECODE: done = !op_known(32'(opc_d));
      S_EXEC:   done = (opc_q == OPC_W'(OP_BEQ));
      S_MEM: begin
        MemRead  = (opc_q == OPC_W'(OP_LW));
        MemWrite = (opc_q == OPC_W'(OP_SW));
        done     = (opc_q == OPC_W'(OP_SW));
      end
      S_WB: begin
        RegWrite = 1'b1;
        done     = 1'b1;
      end
      default: done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Directed plus randomized checks of mem_ctrl_fsm against a per-cycle latency/class model.
module tb_mem_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  addr;
  logic [15:0] din;
  logic        wea;
  logic [15:0] douta;
  logic        busy, done, ALUSrc, MemtoReg, RegDst, Branch, MemRead, MemWrite, RegWrite;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem_m [1024];
  logic [15:0] last_d;
  int unsigned written_q [$];

  always #5 clk = ~clk;

  mem_ctrl_fsm dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .din(din), .wea(wea),
    .douta(douta), .busy(busy), .done(done), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite)
  );

  // Cycles from start to done by instruction class
  function automatic int lat_of(input logic [15:0] w);
    case (w[15:12])
      4'd0: return 4;
      4'd1: return 3;
      4'd2: return 4;
      4'd3: return 5;
      4'd4: return 4;
      default: return 2;
    endcase
  endfunction

  // Expected {douta,busy,done,ALUSrc,MemtoReg,RegDst,Branch,MemRead,MemWrite,RegWrite} in cycle k
  function automatic logic [24:0] expect_at(input logic [15:0] w, input int k, input logic [15:0] dprev);
    logic [3:0] op;
    logic cls, a, m2r, rd, br, mr, mw, rw;
    op  = w[15:12];
    cls = (op <= 4'd4) && (k >= 3);
    a   = cls && (op == 4'd2 || op == 4'd3 || op == 4'd4);
    m2r = cls && (op == 4'd3);
    rd  = cls && (op == 4'd0);
    br  = cls && (op == 4'd1);
    mr  = (op == 4'd3) && (k == 4);
    mw  = (op == 4'd2) && (k == 4);
    rw  = ((op == 4'd0 || op == 4'd4) && k == 4) || (op == 4'd3 && k == 5);
    return {(k >= 2) ? w : dprev, 1'b1, (k == lat_of(w)), a, m2r, rd, br, mr, mw, rw};
  endfunction

  function automatic logic [24:0] idle_vec(input logic [15:0] d);
    return {d, 9'b0};
  endfunction

  task automatic check(input string tag, input logic [24:0] exp);
    logic [24:0] obs;
    obs = {douta, busy, done, ALUSrc, MemtoReg, RegDst, Branch, MemRead, MemWrite, RegWrite};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge with the DUT in IDLE
  task automatic load(input logic [9:0] a, input logic [15:0] d);
    addr = a; din = d; wea = 1'b1;
    @(negedge clk);
    wea = 1'b0;
    mem_m[a] = d;
    written_q.push_back(32'(a));
    check("load_idle", idle_vec(last_d));
  endtask

  task automatic run(input logic [9:0] a, input bit wr, input logic [15:0] wd,
                     input bit junk, input bit rst_mem, input string tag);
    logic [15:0] w;
    int lat;
    bit aborted;
    aborted = 1'b0;
    addr = a; start = 1'b1;
    if (wr) begin
      wea = 1'b1; din = wd; mem_m[a] = wd;
    end
    w   = mem_m[a];
    lat = lat_of(w);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = 1'b0; wea = 1'b0;
      if (junk && k == 1) begin
        start = 1'b1; wea = 1'b1; addr = 10'd5; din = 16'hDEAD;
      end
      check($sformatf("%s_c%0d", tag, k), expect_at(w, k, last_d));
      if (rst_mem && k == 4) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_d = 16'h0;
        check({tag, "_reset"}, idle_vec(last_d));
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      last_d = w;
      @(negedge clk);
      check({tag, "_idle"}, idle_vec(last_d));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; wea = 1'b0; addr = '0; din = '0;
    last_d = 16'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", idle_vec(16'h0));
    reset = 1'b0;
    @(negedge clk);

    // Program load and each instruction class
    load(10'd0, 16'h0123);
    load(10'd1, 16'h1000);
    load(10'd2, 16'h2000);
    load(10'd3, 16'h3000);
    load(10'd5, 16'hF000);
    run(10'd0, 0, 16'h0, 0, 0, "rtype");
    run(10'd1, 0, 16'h0, 0, 0, "beq");
    run(10'd2, 0, 16'h0, 0, 0, "sw");
    run(10'd3, 0, 16'h0, 0, 0, "lw");
    run(10'd5, 0, 16'h0, 0, 0, "nop");

    // start/wea while busy are ignored; mem[5] readback unchanged
    run(10'd3, 0, 16'h0, 1, 0, "busy_junk");
    run(10'd5, 0, 16'h0, 0, 0, "readback5");

    // Reset in MEM of sw, then mem[2] readback
    run(10'd2, 0, 16'h0, 0, 1, "sw_rst");
    run(10'd2, 0, 16'h0, 0, 0, "readback2");

    // Simultaneous write and start at the same address
    run(10'd7, 1, 16'h4000, 0, 0, "collide");
    written_q.push_back(32'd7);

    // Randomized program and instruction stream
    for (int i = 0; i < 24; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) w[15:12] = 4'($urandom_range(8, 15));
      load(10'($urandom_range(16, 1023)), w);
    end
    for (int i = 0; i < 40; i++) begin
      logic [9:0] a;
      logic [15:0] wd;
      bit wr;
      a  = 10'(written_q[$urandom_range(0, written_q.size() - 1)]);
      wr = ($urandom_range(0, 4) == 0);
      wd = 16'($urandom);
      wd[15:12] = 4'($urandom_range(0, 9));
      run(a, wr, wd, bit'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        check("rnd_gap", idle_vec(last_d));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_fsm.md
# mem_ctrl_fsm

Parametrised successor to the instruction memory and single-cycle control block of the 16-bit processor. A synchronous program RAM sits behind a multi-cycle control FSM. Per `start`, the FSM fetches one instruction word, decodes its opcode and steps through EXEC/MEM/WB. Control signals are qualified per state rather than held for the whole instruction. The block sits between the PC/fetch logic and the datapath, replacing the combinational decode used by the first-generation memory block.

## Interface
- `DATA_W`, 16: instruction/data word width.
- `ADDR_W`, 10: RAM address width; depth is 2^ADDR_W.
- `OPC_W`, 4: opcode field width, taken from `douta[DATA_W-1 -: OPC_W]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin one instruction; sampled only in IDLE.
- `addr` in ADDR_W: fetch address when `start`; write address when `wea`.
- `din` in DATA_W: program load data.
- `wea` in 1: RAM write enable; honoured only in IDLE.
- `douta` out DATA_W: registered RAM read data, i.e. the last fetched instruction.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse in the final state of an instruction.
- `ALUSrc`, `MemtoReg`, `RegDst`, `Branch` out 1: decoded class signals, held from EXEC to end of instruction.
- `MemRead`, `MemWrite` out 1: high only in MEM.
- `RegWrite` out 1: high only in WB.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE → FETCH on `start`; `addr` is latched.
- FETCH: RAM read is issued.
- DECODE: `douta` is valid; the opcode is latched into an internal instruction register.
- Opcodes and their paths:
  - 0 R-type: DECODE→EXEC→WB; `RegDst`=1, `RegWrite`=1 in WB.
  - 1 beq: DECODE→EXEC; `Branch`=1 in EXEC; `done` in EXEC.
  - 2 sw: DECODE→EXEC→MEM; `ALUSrc`=1; `MemWrite`=1 in MEM.
  - 3 lw: DECODE→EXEC→MEM→WB; `ALUSrc`=1, `MemtoReg`=1; `MemRead`=1 in MEM; `RegWrite`=1 in WB.
  - 4 addi: DECODE→EXEC→WB; `ALUSrc`=1, `RegWrite`=1 in WB.
  - Any other opcode is a NOP: `done` in DECODE, all control signals 0.
- Every final state returns to IDLE on the next edge.
- `start` while `busy` is ignored (not queued).
- `wea` while `busy` is ignored; no write occurs.
- A write in IDLE updates the RAM only; `douta` is unchanged.
- `start` and `wea` in the same IDLE cycle: the write commits and the fetch begins. When `addr` is the same for both, FETCH returns the new `din`.

## Timing
- Reset values: all control outputs 0, `done`=0, `busy`=0, `douta`=0, state IDLE.
- RAM contents are not cleared by reset.
- `reset` mid-instruction: IDLE on the next edge. All outputs are 0 that cycle, with no `done` and no pending `MemWrite`.
- Start accepted at edge 0. FETCH is cycle 1, DECODE cycle 2 (`douta` valid), EXEC cycle 3.
- `done` cycle and start-to-done latency by class:
  - NOP: cycle 2.
  - beq: cycle 3.
  - sw: cycle 4 (MEM).
  - R-type and addi: cycle 4 (WB).
  - lw: cycle 5 (WB).
- Back-to-back: `start` may be high in the cycle after `done` (IDLE). The next FETCH follows one cycle later.
- Outputs are registered from state; no combinational path from inputs to outputs.
- Address arithmetic: none. `addr` wraps naturally at 2^ADDR_W.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the opcode constants (OP_RTYPE=0, OP_BEQ=1, OP_SW=2, OP_LW=3, OP_ADDI=4);
  - the state enum;
  - a packed control struct {ALUSrc, MemtoReg, RegDst, Branch}.
- Sub-module `sp_ram_sync`: parametrised single-port RAM with synchronous write, registered read and write-first behaviour.
- FSM and decode stay in `mem_ctrl_fsm`.

## Test plan
- Program load and timing:
  - Stimulus: write mem[0]=16'h0123, mem[1]=16'h1000, mem[2]=16'h2000, mem[3]=16'h3000, mem[5]=16'hF000 in IDLE, then start at addr 0.
  - Response: `douta`=16'h0123 in cycle 2; `RegDst`=1 in EXEC/WB; `RegWrite` high only in cycle 4; `done` in cycle 4.
- beq and sw:
  - Stimulus: start at addr 1.
  - Response: `Branch`=1 and `done` in cycle 3, `RegWrite`=0 throughout.
  - Stimulus: start at addr 2.
  - Response: `MemWrite`=1 only in cycle 4, `ALUSrc`=1.
- lw:
  - Stimulus: start at addr 3.
  - Response: `MemRead`=1 in cycle 4; `RegWrite`=1 and `MemtoReg`=1 in cycle 5; `done` in cycle 5.
- NOP and ignored inputs:
  - Stimulus: start at addr 5.
  - Response: `done` in cycle 2, all control 0.
  - Stimulus: `start` and `wea` pulsed while `busy`.
  - Response: no new fetch; RAM unchanged on readback.
- Reset and write collision:
  - Stimulus: `reset` in MEM of a sw.
  - Response: `MemWrite`=0 on the next cycle, IDLE, mem[2] still 16'h2000.
  - Stimulus: simultaneous `wea`+`start` at addr 7 with `din`=16'h4000.
  - Response: addi path, `done` in cycle 4.
